buttons: RTL and testbench
==========================

Name: buttons

Overview:
- Request-latch block for the elevator controller.
- Captures floor requests from three button banks: in-car floor buttons, hall "up" buttons and hall "down" buttons.
- Holds each request as a sticky active bit until the elevator controller inactivates it after the floor is served.
- Sits between the button inputs and the elevator scheduling FSM.

Parameters:
- BUTTONS_WIDTH, 8, number of floors; one bit per floor in every vector (bit i = floor i).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_in  input  BUTTONS_WIDTH  in-car floor buttons; level, 1 = pressed.
- btn_up_out  input  BUTTONS_WIDTH  hall up-call buttons; level, 1 = pressed.
- btn_down_out  input  BUTTONS_WIDTH  hall down-call buttons; level, 1 = pressed.
- inactivate_in_levels  input  BUTTONS_WIDTH  per-floor clear for in-car requests; 1 = clear.
- inactivate_out_up_levels  input  BUTTONS_WIDTH  per-floor clear for up-call requests.
- inactivate_out_down_levels  input  BUTTONS_WIDTH  per-floor clear for down-call requests.
- active_in_levels  output  BUTTONS_WIDTH  pending in-car requests; registered.
- active_out_up_levels  output  BUTTONS_WIDTH  pending up-call requests; registered.
- active_out_down_levels  output  BUTTONS_WIDTH  pending down-call requests; registered.

Behaviour:
- Three independent channels (in, up, down), each BUTTONS_WIDTH independent bits; no interaction between bits or between channels.
- reset low (asynchronous): all three active vectors go to 0 immediately and stay 0 while reset is low. Button presses during reset are ignored.
- Reset deassertion is synchronised internally through a 2-flop release so the first update happens cleanly on a clock edge.
- Per bit, at each rising clk edge when not in reset: active_next = (active | btn) & ~inactivate.
- Set: a button sampled high on an edge sets its bit. Latency is 1 clock; the output is visible after that edge.
- Sticky: once set, the bit stays 1 after the button is released, until cleared.
- Clear: inactivate sampled high clears the bit on that edge.
- Clear has priority. Button and inactivate high on the same edge gives 0. A button held while its inactivate is held stays 0. It sets on the first edge after inactivate drops, if the button is still held.
- Inactivate on an already-idle bit has no effect.
- Buttons are level-sampled, with no edge detection and no debouncing; a press shorter than one clock period and not spanning an edge may be missed.
- Outputs come directly from flops; there is no combinational path from input to output.
- All 8 bits are handled uniformly, including bit 0 and bit BUTTONS_WIDTH-1. Hall up-call at the top floor and down-call at floor 0 are still latched; filtering them is the scheduler's job.

Decomposition:
- Shared package elevator_pkg: BUTTONS_WIDTH default constant and a floor-vector typedef, logic [BUTTONS_WIDTH-1:0].
- One sub-module, request_latch, holding one parameterised channel: btn, inactivate and active vectors plus the clear-priority rule.
- buttons instantiates request_latch three times and contains the reset-release synchroniser.

Test Plan:
- Reset: drive reset=0 with arbitrary buttons -> all active outputs 0 asynchronously. Release reset -> outputs remain 0 with no buttons pressed.
- Latch/sticky: btn_up_out[4]=1 for one edge, then 0 -> active_out_up_levels=8'h10 after that edge, and it holds 8'h10 for the next 10 cycles.
- Multi-channel: press btn_up_out[5], btn_in[1], btn_down_out[7], then release all -> up=8'h30 (with [4] still set), in=8'h02, down=8'h80.
- Clear: assert inactivate_in_levels[1]=1 for one edge -> active_in_levels goes 8'h02 to 8'h00 one cycle later. Deassert it -> remains 0.
- Clear priority: btn_in[2]=1 while inactivate_in_levels[2]=1 -> active_in_levels[2] stays 0. Drop inactivate with the button still held -> bit 2 becomes 1 on the next edge.
- Reset mid-operation: with several bits active, pulse reset low between clock edges -> outputs clear immediately. Afterwards btn_down_out[6]=1 and btn_up_out[5]=1 -> down=8'h40, up=8'h20; then btn_up_out[2], btn_down_out[1] -> up=8'h24, down=8'h42.

Source files
------------

// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator controller slice.
//   DEFAULT_BUTTONS_WIDTH : number of floors served (one bit per floor)
//   floor_vec_t           : one bit per floor, bit i = floor i
//   latch_next()          : next value of a sticky request vector; a clear
//                           overrides a press on the same edge
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int unsigned DEFAULT_BUTTONS_WIDTH = 32'd8;

    typedef logic [DEFAULT_BUTTONS_WIDTH-1:0] floor_vec_t;

    // Sticky set, clear has priority over set.
    function automatic floor_vec_t latch_next(
        input floor_vec_t active,
        input floor_vec_t btn,
        input floor_vec_t clr
    );
        return (active | btn) & ~clr;
    endfunction

endpackage : elevator_pkg

// File: rtl/request_latch.sv
// -----------------------------------------------------------------------------
// request_latch
// One request channel: WIDTH independent sticky bits. A bit is set by its
// button sampled high on a clock edge and cleared by its inactivate sampled
// high on an edge; clear wins when both are high.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset, clears every bit
//   enable     : updates allowed (low while reset release is being synchronised)
//   btn        : level button inputs, 1 = pressed
//   inactivate : level per-bit clear, 1 = clear
//   active     : pending requests, straight from flops
// -----------------------------------------------------------------------------
module request_latch
    import elevator_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_BUTTONS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] btn,
    input  logic [WIDTH-1:0] inactivate,
    output logic [WIDTH-1:0] active
);

    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] active_nxt_s;

    // Next-state: sticky set with clear priority, hold while updates are disabled.
    always_comb begin
        active_nxt_s = active_r;
        if (enable) begin
            active_nxt_s = (active_r | btn) & ~inactivate;
        end else begin
            active_nxt_s = active_r;
        end
    end

    // Request state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= {WIDTH{1'b0}};
        end else begin
            active_r <= active_nxt_s;
        end
    end

    assign active = active_r;

endmodule : request_latch

// File: rtl/buttons.sv
// -----------------------------------------------------------------------------
// buttons
// Request-latch block between the elevator button banks and the scheduler.
// Holds in-car, hall-up and hall-down requests as sticky bits until the
// scheduler clears them after serving the floor.
// Ports:
//   clk                        : system clock, rising edge
//   reset                      : asynchronous active-low reset
//   btn_in                     : in-car floor buttons (level)
//   btn_up_out                 : hall up-call buttons (level)
//   btn_down_out               : hall down-call buttons (level)
//   inactivate_in_levels       : per-floor clear, in-car requests
//   inactivate_out_up_levels   : per-floor clear, up-call requests
//   inactivate_out_down_levels : per-floor clear, down-call requests
//   active_in_levels           : pending in-car requests (registered)
//   active_out_up_levels       : pending up-call requests (registered)
//   active_out_down_levels     : pending down-call requests (registered)
// Reset asserts asynchronously; its release is passed through two flops so
// the request channels start updating cleanly on a clock edge. Hall up at the
// top floor and down at floor 0 are latched like any other bit; filtering
// them belongs to the scheduler.
// -----------------------------------------------------------------------------
module buttons
    import elevator_pkg::*;
#(
    parameter int unsigned BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] btn_in,
    input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] active_in_levels,
    output logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0] active_out_down_levels
);

    logic [1:0] rst_sync_r;
    logic       run_en_s;

    // Reset-release synchroniser: clears at once, releases after two edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign run_en_s = rst_sync_r[1];

    request_latch #(
        .WIDTH (BUTTONS_WIDTH)
    ) u_latch_in (
        .clk        (clk),
        .rst_n      (reset),
        .enable     (run_en_s),
        .btn        (btn_in),
        .inactivate (inactivate_in_levels),
        .active     (active_in_levels)
    );

    request_latch #(
        .WIDTH (BUTTONS_WIDTH)
    ) u_latch_up (
        .clk        (clk),
        .rst_n      (reset),
        .enable     (run_en_s),
        .btn        (btn_up_out),
        .inactivate (inactivate_out_up_levels),
        .active     (active_out_up_levels)
    );

    request_latch #(
        .WIDTH (BUTTONS_WIDTH)
    ) u_latch_down (
        .clk        (clk),
        .rst_n      (reset),
        .enable     (run_en_s),
        .btn        (btn_down_out),
        .inactivate (inactivate_out_down_levels),
        .active     (active_out_down_levels)
    );

endmodule : buttons

// File: tb/tb_buttons.sv
// -----------------------------------------------------------------------------
// tb_buttons
// Directed self-checking bench for the buttons request-latch block.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_buttons;

    logic       clk;
    logic       reset;
    logic [7:0] btn_in;
    logic [7:0] btn_up_out;
    logic [7:0] btn_down_out;
    logic [7:0] inactivate_in_levels;
    logic [7:0] inactivate_out_up_levels;
    logic [7:0] inactivate_out_down_levels;
    logic [7:0] active_in_levels;
    logic [7:0] active_out_up_levels;
    logic [7:0] active_out_down_levels;

    int vecs;
    int errs;

    buttons #(
        .BUTTONS_WIDTH (8)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .btn_in                     (btn_in),
        .btn_up_out                 (btn_up_out),
        .btn_down_out               (btn_down_out),
        .inactivate_in_levels       (inactivate_in_levels),
        .inactivate_out_up_levels   (inactivate_out_up_levels),
        .inactivate_out_down_levels (inactivate_out_down_levels),
        .active_in_levels           (active_in_levels),
        .active_out_up_levels       (active_out_up_levels),
        .active_out_down_levels     (active_out_down_levels)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn_in = 8'hFF;
        btn_up_out = 8'hA5;
        btn_down_out = 8'h5A;
        #3;
        vecs++;
        if (active_in_levels !== 8'h00) begin
            errs++;
            $display("FAIL reset_in: got %h expected %h", active_in_levels, 8'h00);
        end
        vecs++;
        if (active_out_up_levels !== 8'h00) begin
            errs++;
            $display("FAIL reset_up: got %h expected %h", active_out_up_levels, 8'h00);
        end
        vecs++;
        if (active_out_down_levels !== 8'h00) begin
            errs++;
            $display("FAIL reset_down: got %h expected %h", active_out_down_levels, 8'h00);
        end
        // Buttons held through several edges under reset must be ignored.
        tick();
        tick();
        vecs++;
        if ((active_in_levels | active_out_up_levels | active_out_down_levels) !== 8'h00) begin
            errs++;
            $display("FAIL reset_hold: got in=%h up=%h down=%h expected 00",
                     active_in_levels, active_out_up_levels, active_out_down_levels);
        end
        @(negedge clk);
        btn_in = 8'h00;
        btn_up_out = 8'h00;
        btn_down_out = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        tick();
        vecs++;
        if ((active_in_levels | active_out_up_levels | active_out_down_levels) !== 8'h00) begin
            errs++;
            $display("FAIL reset_release: got in=%h up=%h down=%h expected 00",
                     active_in_levels, active_out_up_levels, active_out_down_levels);
        end
    endtask

    task automatic test_latch_sticky();
        @(negedge clk);
        btn_up_out = 8'h10;
        tick();
        vecs++;
        if (active_out_up_levels !== 8'h10) begin
            errs++;
            $display("FAIL latch_set: got %h expected %h", active_out_up_levels, 8'h10);
        end
        @(negedge clk);
        btn_up_out = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if (active_out_up_levels !== 8'h10) begin
                errs++;
                $display("FAIL sticky_cycle%0d: got %h expected %h", i, active_out_up_levels, 8'h10);
            end
        end
    endtask

    task automatic test_multi_channel();
        @(negedge clk);
        btn_up_out = 8'h20;
        btn_in = 8'h02;
        btn_down_out = 8'h80;
        tick();
        @(negedge clk);
        btn_up_out = 8'h00;
        btn_in = 8'h00;
        btn_down_out = 8'h00;
        tick();
        vecs++;
        if (active_out_up_levels !== 8'h30) begin
            errs++;
            $display("FAIL multi_up: got %h expected %h", active_out_up_levels, 8'h30);
        end
        vecs++;
        if (active_in_levels !== 8'h02) begin
            errs++;
            $display("FAIL multi_in: got %h expected %h", active_in_levels, 8'h02);
        end
        vecs++;
        if (active_out_down_levels !== 8'h80) begin
            errs++;
            $display("FAIL multi_down: got %h expected %h", active_out_down_levels, 8'h80);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        inactivate_in_levels = 8'h02;
        tick();
        vecs++;
        if (active_in_levels !== 8'h00) begin
            errs++;
            $display("FAIL clear_in: got %h expected %h", active_in_levels, 8'h00);
        end
        vecs++;
        if (active_out_up_levels !== 8'h30) begin
            errs++;
            $display("FAIL clear_isolation_up: got %h expected %h", active_out_up_levels, 8'h30);
        end
        @(negedge clk);
        inactivate_in_levels = 8'h00;
        tick();
        vecs++;
        if (active_in_levels !== 8'h00) begin
            errs++;
            $display("FAIL clear_stays: got %h expected %h", active_in_levels, 8'h00);
        end
        // Clear only the up bit 4; bit 5 and the down channel are untouched.
        @(negedge clk);
        inactivate_out_up_levels = 8'h10;
        tick();
        @(negedge clk);
        inactivate_out_up_levels = 8'h00;
        vecs++;
        if (active_out_up_levels !== 8'h20) begin
            errs++;
            $display("FAIL clear_up_bit4: got %h expected %h", active_out_up_levels, 8'h20);
        end
        vecs++;
        if (active_out_down_levels !== 8'h80) begin
            errs++;
            $display("FAIL clear_isolation_down: got %h expected %h", active_out_down_levels, 8'h80);
        end
    endtask

    task automatic test_clear_priority();
        @(negedge clk);
        btn_in = 8'h04;
        inactivate_in_levels = 8'h04;
        tick();
        vecs++;
        if (active_in_levels !== 8'h00) begin
            errs++;
            $display("FAIL prio_same_edge: got %h expected %h", active_in_levels, 8'h00);
        end
        tick();
        vecs++;
        if (active_in_levels !== 8'h00) begin
            errs++;
            $display("FAIL prio_held: got %h expected %h", active_in_levels, 8'h00);
        end
        @(negedge clk);
        inactivate_in_levels = 8'h00;
        tick();
        vecs++;
        if (active_in_levels !== 8'h04) begin
            errs++;
            $display("FAIL prio_release: got %h expected %h", active_in_levels, 8'h04);
        end
        // Clearing an idle bit (bit 0) leaves the active bit 2 alone.
        @(negedge clk);
        btn_in = 8'h00;
        inactivate_in_levels = 8'h01;
        tick();
        vecs++;
        if (active_in_levels !== 8'h04) begin
            errs++;
            $display("FAIL clear_idle: got %h expected %h", active_in_levels, 8'h04);
        end
        @(negedge clk);
        inactivate_in_levels = 8'h00;
    endtask

    task automatic test_boundary_bits();
        @(negedge clk);
        btn_up_out = 8'h80;
        btn_down_out = 8'h01;
        btn_in = 8'h81;
        tick();
        @(negedge clk);
        btn_up_out = 8'h00;
        btn_down_out = 8'h00;
        btn_in = 8'h00;
        vecs++;
        if (active_out_up_levels !== 8'hA0) begin
            errs++;
            $display("FAIL boundary_up_top: got %h expected %h", active_out_up_levels, 8'hA0);
        end
        vecs++;
        if (active_out_down_levels !== 8'h81) begin
            errs++;
            $display("FAIL boundary_down_floor0: got %h expected %h", active_out_down_levels, 8'h81);
        end
        vecs++;
        if (active_in_levels !== 8'h85) begin
            errs++;
            $display("FAIL boundary_in: got %h expected %h", active_in_levels, 8'h85);
        end
    endtask

    task automatic test_reset_mid();
        // Pulse reset between edges while several bits are active.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        vecs++;
        if ((active_in_levels | active_out_up_levels | active_out_down_levels) !== 8'h00) begin
            errs++;
            $display("FAIL reset_mid_async: got in=%h up=%h down=%h expected 00",
                     active_in_levels, active_out_up_levels, active_out_down_levels);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        btn_down_out = 8'h40;
        btn_up_out = 8'h20;
        tick();
        @(negedge clk);
        btn_down_out = 8'h02;
        btn_up_out = 8'h04;
        vecs++;
        if (active_out_down_levels !== 8'h40) begin
            errs++;
            $display("FAIL reset_mid_down: got %h expected %h", active_out_down_levels, 8'h40);
        end
        vecs++;
        if (active_out_up_levels !== 8'h20) begin
            errs++;
            $display("FAIL reset_mid_up: got %h expected %h", active_out_up_levels, 8'h20);
        end
        tick();
        @(negedge clk);
        btn_down_out = 8'h00;
        btn_up_out = 8'h00;
        vecs++;
        if (active_out_up_levels !== 8'h24) begin
            errs++;
            $display("FAIL back_to_back_up: got %h expected %h", active_out_up_levels, 8'h24);
        end
        vecs++;
        if (active_out_down_levels !== 8'h42) begin
            errs++;
            $display("FAIL back_to_back_down: got %h expected %h", active_out_down_levels, 8'h42);
        end
        vecs++;
        if (active_in_levels !== 8'h00) begin
            errs++;
            $display("FAIL reset_mid_in: got %h expected %h", active_in_levels, 8'h00);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        reset = 1'b0;
        btn_in = 8'h00;
        btn_up_out = 8'h00;
        btn_down_out = 8'h00;
        inactivate_in_levels = 8'h00;
        inactivate_out_up_levels = 8'h00;
        inactivate_out_down_levels = 8'h00;

        test_reset();
        test_latch_sticky();
        test_multi_channel();
        test_clear();
        test_clear_priority();
        test_boundary_bits();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_buttons
